// File: rtl/pwm_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cfg_sched
// Purpose  : Round-robin scheduler that shares a single PWM configuration bus
//            (d/sel, one write per cycle) among N requesters. Each grant runs
//            as an atomic burst: cmp write, top write, optional counter
//            restart, then a one-cycle ack. A burst can optionally wait for
//            the PWM period boundary before its first write.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req[N]            - per-requester request, held until ack
//            cmp_in/top_in     - per-requester values, slice i at [i*W +: W]
//            restart[N]        - zero the PWM counter after the top write
//            sync_en           - align burst to pwm_cnt == pwm_top
//            pwm_cnt/pwm_top   - PWM monitor inputs
//            pwm_d/pwm_sel     - PWM config bus (sel 0 idle,1 cmp,2 top,3 cnt)
//            ack[N]            - one-hot one-cycle completion pulse
//            busy, grant_id    - burst in progress and its owner
// Revision : 1.0 - initial release
// ============================================================================
module pwm_cfg_sched #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       cmp_in,
  input  logic [N*W-1:0]       top_in,
  input  logic [N-1:0]         restart,
  input  logic                 sync_en,
  input  logic [W-1:0]         pwm_cnt,
  input  logic [W-1:0]         pwm_top,
  output logic [W-1:0]         pwm_d,
  output logic [1:0]           pwm_sel,
  output logic [N-1:0]         ack,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int            IW      = $clog2(N);
  localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_SYNC = 3'd1,
    S_WR_CMP    = 3'd2,
    S_WR_TOP    = 3'd3,
    S_WR_CNT    = 3'd4,
    S_ACK       = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [W-1:0]    cmp_q, cmp_d;
  logic [W-1:0]    top_q, top_d;
  logic            restart_q, restart_d;

  logic [1:0]      sel_q, sel_d;
  logic [W-1:0]    data_q, data_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;

  // Round-robin search starting one past the last winner; the last
  // candidate examined is ptr itself, so a lone requester can win again.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic. Request data is captured only at grant so later
  // changes on the requester inputs cannot disturb a burst in flight.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    cmp_d     = cmp_q;
    top_d     = top_q;
    restart_d = restart_q;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          ptr_d     = win_idx;
          gid_d     = win_idx;
          cmp_d     = cmp_in[win_idx*W +: W];
          top_d     = top_in[win_idx*W +: W];
          restart_d = restart[win_idx];
          state_d   = sync_en ? S_WAIT_SYNC : S_WR_CMP;
        end
      end
      S_WAIT_SYNC: begin
        if ((pwm_cnt == pwm_top) || !sync_en) begin
          state_d = S_WR_CMP;
        end
      end
      // cmp always precedes top so a shrinking period never meets a stale,
      // larger compare value.
      S_WR_CMP: state_d = S_WR_TOP;
      S_WR_TOP: state_d = restart_q ? S_WR_CNT : S_ACK;
      S_WR_CNT: state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and carry no combinational path from inputs.
  always_comb begin
    sel_d  = 2'd0;
    data_d = '0;
    ack_d  = '0;
    busy_d = (state_d != S_IDLE);
    unique case (state_d)
      S_WR_CMP: begin
        sel_d  = 2'd1;
        data_d = cmp_d;
      end
      S_WR_TOP: begin
        sel_d  = 2'd2;
        data_d = top_d;
      end
      S_WR_CNT: begin
        sel_d  = 2'd3;
        data_d = '0;
      end
      S_ACK: begin
        ack_d[gid_d] = 1'b1;
      end
      default: begin
        sel_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_RST;
      gid_q     <= '0;
      cmp_q     <= '0;
      top_q     <= '0;
      restart_q <= 1'b0;
      sel_q     <= 2'd0;
      data_q    <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      cmp_q     <= cmp_d;
      top_q     <= top_d;
      restart_q <= restart_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
    end
  end

  assign pwm_sel  = sel_q;
  assign pwm_d    = data_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cfg_sched
// Purpose  : Self-checking bench for pwm_cfg_sched with a small behavioural
//            PWM counter model and an ordered scoreboard of expected bus
//            writes and acks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pwm_cfg_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   restart = '0;
  logic [N*W-1:0] cmp_in = '0;
  logic [N*W-1:0] top_in = '0;
  logic           sync_en = 1'b0;
  logic [W-1:0]   pwm_cnt, pwm_top, pwm_d;
  logic [1:0]     pwm_sel;
  logic [N-1:0]   ack;
  logic           busy;
  logic [IW-1:0]  grant_id;

  // PWM model: registers take bus writes; counter wraps at top.
  logic [W-1:0]   m_cnt = '0;
  logic [W-1:0]   m_cmp = '0;
  logic [W-1:0]   m_top = '0;

  always #5 clk = ~clk;

  pwm_cfg_sched #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .cmp_in   (cmp_in),
    .top_in   (top_in),
    .restart  (restart),
    .sync_en  (sync_en),
    .pwm_cnt  (pwm_cnt),
    .pwm_top  (pwm_top),
    .pwm_d    (pwm_d),
    .pwm_sel  (pwm_sel),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id)
  );

  assign pwm_cnt = m_cnt;
  assign pwm_top = m_top;

  always @(posedge clk) begin
    if (pwm_sel == 2'd1) m_cmp <= pwm_d;
    if (pwm_sel == 2'd2) m_top <= pwm_d;
    if (pwm_sel == 2'd3) m_cnt <= pwm_d;
    else                 m_cnt <= (m_cnt >= m_top) ? '0 : m_cnt + 1'b1;
  end

  // kind: 1 cmp write, 2 top write, 3 cnt write, 4 ack (data = ack vector)
  typedef struct {
    int         kind;
    logic [W-1:0] data;
    int         gid;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and queue the burst it must produce.
  task automatic drive(input int i, input int c, input int t, input bit rs);
    cmp_in[i*W +: W] = W'(c);
    top_in[i*W +: W] = W'(t);
    restart[i]       = rs;
    req[i]           = 1'b1;
    sb.push_back('{kind: 1, data: W'(c), gid: i});
    sb.push_back('{kind: 2, data: W'(t), gid: i});
    if (rs) sb.push_back('{kind: 3, data: '0, gid: i});
    sb.push_back('{kind: 4, data: W'(1 << i), gid: i});
  endtask

  // Wait for n acks; each acked requester drops req on the edge ending its ack.
  task automatic serve(input int n);
    for (int j = 0; j < n; j++) begin
      int cyc;
      logic [N-1:0] a;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (ack == '0 && cyc < 60);
      check_eq("ack_seen", 64'(ack != '0), 1);
      a = ack;
      @(posedge clk);
      #1 req = req & ~a;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    sync_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // Scoreboard monitor: every bus write or ack must match the queue head.
  always @(negedge clk) begin
    ev_t e;
    int  ok_kind;
    logic [W-1:0] ok_data;
    if (pwm_sel != 2'd0 || ack != '0) begin
      ok_kind = (ack != '0) ? 4 : int'(pwm_sel);
      ok_data = (ack != '0) ? W'(ack) : pwm_d;
      if (sb.size() == 0) begin
        check_eq("unexpected_evt", 64'({pwm_sel, ack}), 0);
      end else begin
        e = sb.pop_front();
        check_eq("sb_kind", 64'(ok_kind), 64'(e.kind));
        check_eq("sb_data", 64'(ok_data), 64'(e.data));
        check_eq("sb_gid",  64'(grant_id), 64'(e.gid));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    logic [W-1:0] prev;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_sel",  64'(pwm_sel), 0);
    check_eq("rst_d",    64'(pwm_d), 0);
    check_eq("rst_ack",  64'(ack), 0);
    check_eq("rst_busy", 64'(busy), 0);
    check_eq("rst_gid",  64'(grant_id), 0);

    // ---------------- single request, latency ----------------
    tick();
    drive(0, 100, 400, 1'b0);
    @(negedge clk); // cycle 0
    check_eq("t1_c0_busy", 64'(busy), 0);
    @(negedge clk); // cycle 1
    check_eq("t1_c1_sel",  64'(pwm_sel), 1);
    check_eq("t1_c1_d",    64'(pwm_d), 100);
    check_eq("t1_c1_busy", 64'(busy), 1);
    @(negedge clk); // cycle 2
    check_eq("t1_c2_sel",  64'(pwm_sel), 2);
    check_eq("t1_c2_d",    64'(pwm_d), 400);
    @(negedge clk); // cycle 3
    check_eq("t1_c3_ack",  64'(ack), 1);
    check_eq("t1_c3_busy", 64'(busy), 1);
    check_eq("t1_c3_sel",  64'(pwm_sel), 0);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk); // cycle 4
    check_eq("t1_c4_busy", 64'(busy), 0);
    check_eq("t1_c4_ack",  64'(ack), 0);

    // ---------------- restart ----------------
    tick();
    drive(0, 100, 400, 1'b1);
    @(negedge clk); // cycle 0
    @(negedge clk); // cycle 1
    @(negedge clk); // cycle 2
    @(negedge clk); // cycle 3
    check_eq("t2_c3_sel", 64'(pwm_sel), 3);
    check_eq("t2_c3_d",   64'(pwm_d), 0);
    check_eq("t2_c3_ack", 64'(ack), 0);
    @(negedge clk); // cycle 4
    check_eq("t2_c4_ack", 64'(ack), 1);
    check_eq("t2_c4_cnt", 64'(m_cnt), 0);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check_eq("t2_c5_busy", 64'(busy), 0);

    // ---------------- fairness ----------------
    tick();
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 10 + i, 1000 + i, 1'b0);
    serve(4);
    drive(0, 20, 900, 1'b0);
    drive(2, 22, 902, 1'b0);
    serve(2);

    // ---------------- sync alignment ----------------
    drive(1, 5, 9, 1'b0);
    serve(1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (m_cnt != 2 && cyc < 40);
    check_eq("sync_cnt2_found", 64'(m_cnt), 2);
    @(posedge clk);
    #1 sync_en = 1'b1;
    drive(2, 6, 9, 1'b0);
    prev = m_cnt;
    k = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      k = n;
      if (pwm_sel != 2'd0) break;
      if (n >= 1) check_eq("sync_hold_busy", 64'(busy), 1);
      prev = m_cnt;
    end
    check_eq("sync_first_wr_cycle", 64'(k), 7);
    check_eq("sync_prev_cnt", 64'(prev), 9);
    serve(1);

    // drop sync_en while waiting
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (m_cnt != 0 && cyc < 40);
    @(posedge clk);
    #1 sync_en = 1'b1;
    drive(3, 7, 9, 1'b0);
    @(negedge clk); // cycle 0
    @(negedge clk); // cycle 1
    check_eq("nosync_c1_sel", 64'(pwm_sel), 0);
    @(negedge clk); // cycle 2
    check_eq("nosync_c2_sel", 64'(pwm_sel), 0);
    check_eq("nosync_c2_busy", 64'(busy), 1);
    @(posedge clk);
    #1 sync_en = 1'b0;
    @(negedge clk); // cycle 3, still waiting
    check_eq("nosync_c3_sel", 64'(pwm_sel), 0);
    @(negedge clk); // cycle 4
    check_eq("nosync_c4_sel", 64'(pwm_sel), 1);
    check_eq("nosync_c4_d",   64'(pwm_d), 7);
    serve(1);

    // ---------------- input stability ----------------
    drive(1, 50, 9, 1'b0);
    tick();
    cmp_in[1*W +: W] = W'(77);
    serve(1);
    check_eq("stab_model_cmp", 64'(m_cmp), 50);

    // ---------------- reset in WR_TOP ----------------
    tick();
    drive(2, 20, 9, 1'b0);
    @(negedge clk); // cycle 0
    @(negedge clk); // cycle 1
    @(negedge clk); // cycle 2
    check_eq("rtop_c2_sel", 64'(pwm_sel), 2);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk); // cycle 3
    check_eq("rtop_c3_sel",  64'(pwm_sel), 0);
    check_eq("rtop_c3_busy", 64'(busy), 0);
    check_eq("rtop_c3_ack",  64'(ack), 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check_eq("rtop_no_ack", 64'(ack), 0);
    end
    tick();
    drive(0, 30, 9, 1'b0);
    drive(3, 33, 9, 1'b0);
    serve(2);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_cfg_sched.md
# pwm_cfg_sched

Round-robin configuration scheduler for a single `PWM_in` channel. It shares the channel's one-write-per-cycle `d`/`sel` configuration bus among N requesters. Each granted request is sequenced as an atomic compare/top (and optional counter-restart) write burst, optionally aligned to the PWM period boundary. It sits between software/control agents and the PWM instance, and is the only driver of that instance's `d` and `sel`.

## Interface
Parameters:
- `N`, default 4. Number of requesters, 2..8.
- `W`, default 16. Data width; must match the PWM `d`/`cnt`/`top` width.

Ports:
- `clk` in, 1. Single clock; all state updates on the rising edge.
- `rst` in, 1. Reset is synchronous and active-high.
- `req` in, N. Per-requester request; held high until the matching `ack`.
- `cmp_in` in, N*W. Requester i's compare value at bits [i*W +: W].
- `top_in` in, N*W. Requester i's period top at bits [i*W +: W].
- `restart` in, N. Per-requester flag; when set, the PWM counter is zeroed after the top write.
- `sync_en` in, 1. When 1, a burst waits for the PWM period boundary before writing.
- `pwm_cnt` in, W. PWM `cnt` output, monitor only.
- `pwm_top` in, W. PWM `top` output, monitor only.
- `pwm_d` out, W. To PWM `d`.
- `pwm_sel` out, 2. To PWM `sel`: 0 = idle, 1 = cmp, 2 = top, 3 = cnt.
- `ack` out, N. One-hot, one-cycle completion pulse to the granted requester.
- `busy` out, 1. High from grant through the ack cycle.
- `grant_id` out, $clog2(N). Index of the current grant; valid while `busy`.

## Operation
- FSM states: IDLE, WAIT_SYNC, WR_CMP, WR_TOP, WR_CNT, ACK.
- IDLE, no `req` bit set: remain in IDLE.
- IDLE, any `req` bit set:
  - Select the winner round-robin, searching from `ptr+1` modulo N.
  - Latch the winner's `cmp_in`, `top_in` and `restart` slice, set `grant_id`, set `ptr := winner`.
  - Go to WAIT_SYNC if `sync_en`, else go to WR_CMP.
- WAIT_SYNC: when `pwm_cnt == pwm_top` or `sync_en == 0`, go to WR_CMP; otherwise stay.
- WR_CMP: `pwm_sel = 1`, `pwm_d =` latched cmp. Go to WR_TOP.
- WR_TOP: `pwm_sel = 2`, `pwm_d =` latched top. Go to WR_CNT if latched `restart`, else go to ACK.
- WR_CNT: `pwm_sel = 3`, `pwm_d = 0`. Go to ACK.
- ACK: `ack[grant_id] = 1` for exactly one cycle. Go to IDLE.
- All write data comes from the latched copy. Requester input changes after grant have no effect on the burst in progress.
- A `req` dropped mid-burst does not abort the burst; the ack is still issued.
- The requester deasserts `req` on the edge ending its ack cycle. A `req` still high in the following IDLE cycle is a new request.
- No `req` is observed outside IDLE; there are no simultaneous grants.
- `pwm_sel = 0` and `pwm_d = 0` in IDLE, WAIT_SYNC and ACK.
- A fresh grant always writes cmp before top, so a reduced top never briefly pairs with a stale cmp larger than the new top.

## Timing
- `rst` sampled high at an edge: state IDLE, `pwm_sel = 0`, `pwm_d = 0`, `ack = 0`, `busy = 0`, `grant_id = 0`, `ptr = N-1` (requester 0 is first priority).
- `rst` mid-burst: the remaining writes are abandoned and no ack is issued. Writes already applied to the PWM stay applied.
- All outputs are registered and reflect the current state.
- Latency with `sync_en = 0`, `req` seen in IDLE at cycle 0:
  - cmp write in cycle 1, top write in cycle 2.
  - cnt write in cycle 3 if `restart`.
  - `ack` in cycle 3 without restart, or cycle 4 with restart.
  - Back in IDLE in cycle 4 or 5.
- Back-to-back requests cost one IDLE cycle between bursts. Minimum burst period is 4 cycles without restart, 5 with restart.
- WAIT_SYNC with `pwm_top == 0` matches immediately, since `pwm_cnt` is 0.
- WAIT_SYNC has no timeout. The PWM guarantees the boundary match because `cnt` wraps at `top`.

## Test plan
- Single request, `sync_en = 0`: `req = 0001`, `cmp_in[0] = 100`, `top_in[0] = 400`, `restart = 0` -> `pwm_sel`/`pwm_d` = 1/100 in cycle 1, 2/400 in cycle 2; `ack = 0001` in cycle 3; `busy` high in cycles 1-3.
- Restart: same as above with `restart[0] = 1` -> 3/0 in cycle 3, ack in cycle 4; PWM `cnt` reads 0 in cycle 4.
- Fairness: `req = 1111` held, each requester dropping its `req` after its ack -> grant order 0, 1, 2, 3. Then re-raise `req[0]` and `req[2]` together -> 0 wins, then 2.
- Sync alignment: `sync_en = 1`, PWM running with top = 9, request raised at `pwm_cnt = 3` -> no write until the cycle after `pwm_cnt == 9`; drop `sync_en` while waiting -> cmp write on the next cycle.
- Input stability: change `cmp_in[1]` from 50 to 77 in the cycle after grant 1 -> `pwm_d = 50` is written.
- Reset in WR_TOP -> next cycle `pwm_sel = 0`, `busy = 0`, no ack; the next request from requester 0 is granted first.
